// File: rtl/data_bus_slave.sv
// -----------------------------------------------------------------------------
// data_bus_slave
//   Memory-mapped slave on a CPU data port: a word-addressed data RAM, a GPIO
//   output register, a synchronised GPIO input port and a 32-bit timer with a
//   compare-match interrupt.
//
//   Address map (word addresses, addr_i[1:0] ignored):
//     0x0000_0000 .. RAM top  data RAM (2**RAM_AW words)
//     0x0000_1000             GPIO_OUT  RW
//     0x0000_1004             GPIO_IN   RO (two-flop synchronised)
//     0x0000_1008             TCOUNT    RW
//     0x0000_100C             TCMP      RW
//     0x0000_1010             TCTRL     RW  [0] EN [1] AUTORELOAD
//                                            [2] MATCH (W1C) [3] IRQ_EN
//     anything else           reads 0, writes ignored
//
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-high reset
//   addr_i   byte address from the CPU data port
//   we_i     store strobe
//   wdata_i  store data
//   rdata_o  load data, registered: reflects addr_i of the previous cycle
//   gpio_out GPIO output register
//   gpio_in  asynchronous GPIO inputs
//   irq_o    timer interrupt (MATCH & IRQ_EN)
// -----------------------------------------------------------------------------
module data_bus_slave #(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq_o
);

  localparam logic [31:0] ADDR_GPIO_OUT = 32'h0000_1000;
  localparam logic [31:0] ADDR_GPIO_IN  = 32'h0000_1004;
  localparam logic [31:0] ADDR_TCOUNT   = 32'h0000_1008;
  localparam logic [31:0] ADDR_TCMP     = 32'h0000_100C;
  localparam logic [31:0] ADDR_TCTRL    = 32'h0000_1010;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL
  } sel_e;

  sel_e              sel;
  logic [31:0]       word_addr;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              unused_addr_lsb;

  logic [31:0]       ram_mem [2**RAM_AW];

  logic [31:0]       rdata_q,    rdata_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_s1_q,  gpio_s1_d;
  logic [GPIO_W-1:0] gpio_s2_q,  gpio_s2_d;
  logic [31:0]       tcount_q,   tcount_d;
  logic [31:0]       tcmp_q,     tcmp_d;
  logic              en_q,       en_d;
  logic              arl_q,      arl_d;
  logic              match_q,    match_d;
  logic              irq_en_q,   irq_en_d;
  logic              cmp_hit;

  assign word_addr       = {addr_i[31:2], 2'b00};
  assign ram_idx         = addr_i[RAM_AW+1:2];
  assign unused_addr_lsb = ^addr_i[1:0];

  // Stores are dropped while reset is asserted; this matters for the RAM,
  // which has no reset of its own.
  assign wr_en = we_i & ~rst;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = SEL_NONE;
    if (addr_i[31:RAM_AW+2] == '0) begin
      sel = SEL_RAM;
    end else begin
      case (word_addr)
        ADDR_GPIO_OUT: sel = SEL_GPIO_OUT;
        ADDR_GPIO_IN:  sel = SEL_GPIO_IN;
        ADDR_TCOUNT:   sel = SEL_TCOUNT;
        ADDR_TCMP:     sel = SEL_TCMP;
        ADDR_TCTRL:    sel = SEL_TCTRL;
        default:       sel = SEL_NONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: built from current (pre-edge) state, so a store and a load to
  // the same address in one cycle returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    case (sel)
      SEL_RAM:      rdata_d = ram_mem[ram_idx];
      SEL_GPIO_OUT: rdata_d = 32'(gpio_out_q);
      SEL_GPIO_IN:  rdata_d = 32'(gpio_s2_q);
      SEL_TCOUNT:   rdata_d = tcount_q;
      SEL_TCMP:     rdata_d = tcmp_q;
      SEL_TCTRL:    rdata_d = {28'd0, irq_en_q, match_q, arl_q, en_q};
      default:      rdata_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // GPIO
  // ---------------------------------------------------------------------------
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_en && sel == SEL_GPIO_OUT) begin
      gpio_out_d = wdata_i[GPIO_W-1:0];
    end
    gpio_s1_d = gpio_in;
    gpio_s2_d = gpio_s1_q;
  end

  // ---------------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------------
  assign cmp_hit = en_q & (tcount_q == tcmp_q);

  always_comb begin
    tcount_d = tcount_q;
    if (en_q) begin
      tcount_d = (cmp_hit && arl_q) ? '0 : tcount_q + 32'd1;
    end
    // A CPU store beats the increment/reload on the same edge.
    if (wr_en && sel == SEL_TCOUNT) begin
      tcount_d = wdata_i;
    end

    tcmp_d = tcmp_q;
    if (wr_en && sel == SEL_TCMP) begin
      tcmp_d = wdata_i;
    end

    en_d     = en_q;
    arl_d    = arl_q;
    irq_en_d = irq_en_q;
    match_d  = match_q;
    if (wr_en && sel == SEL_TCTRL) begin
      en_d     = wdata_i[0];
      arl_d    = wdata_i[1];
      irq_en_d = wdata_i[3];
      if (wdata_i[2]) begin
        match_d = 1'b0;
      end
    end
    // A fresh match overrides a write-1-to-clear on the same edge.
    if (cmp_hit) begin
      match_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) begin
      ram_mem[ram_idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      gpio_out_q <= '0;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      tcount_q   <= '0;
      tcmp_q     <= '0;
      en_q       <= 1'b0;
      arl_q      <= 1'b0;
      match_q    <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
      gpio_s1_q  <= gpio_s1_d;
      gpio_s2_q  <= gpio_s2_d;
      tcount_q   <= tcount_d;
      tcmp_q     <= tcmp_d;
      en_q       <= en_d;
      arl_q      <= arl_d;
      match_q    <= match_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign gpio_out = gpio_out_q;
  assign irq_o    = match_q & irq_en_q;

endmodule

// File: tb/tb_data_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_data_bus_slave
//   Self-checking bench for data_bus_slave: a vector table for the basic
//   address map, hand-written sequences for synchroniser latency, timer
//   match/reload, priority cases and asynchronous reset, then randomised
//   traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_data_bus_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in = '0;
  logic        irq_o;

  data_bus_slave #(.RAM_AW(8), .GPIO_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .gpio_out(gpio_out),
    .gpio_in (gpio_in),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the register file as plain variables, RAM as an array
  // with a written-yet flag per word.
  // ---------------------------------------------------------------------------
  logic [31:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_gpio, m_s1, m_s2;
  logic [31:0] m_tc, m_tcmp;
  bit          m_en, m_ar, m_match, m_ie;
  logic [31:0] exp_rd;
  bit          exp_known;

  task automatic m_reset();
    m_gpio = '0; m_s1 = '0; m_s2 = '0;
    m_tc = '0; m_tcmp = '0;
    m_en = 0; m_ar = 0; m_match = 0; m_ie = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    known = 1;
    if (a < 32'h400) begin
      known = m_known[a[9:2]];
      return m_ram[a[9:2]];
    end
    case (w)
      32'h1000: return {16'h0, m_gpio};
      32'h1004: return {16'h0, m_s2};
      32'h1008: return m_tc;
      32'h100C: return m_tcmp;
      32'h1010: return {28'h0, m_ie, m_match, m_ar, m_en};
      default:  return 32'h0;
    endcase
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [15:0] gin);
    logic [31:0] wa, tc_n;
    bit hit, match_n;
    wa = a & 32'hFFFF_FFFC;
    hit = m_en && (m_tc == m_tcmp);
    tc_n = m_tc;
    if (m_en) tc_n = (hit && m_ar) ? 32'h0 : m_tc + 1;
    match_n = m_match;
    if (w && wa == 32'h1010 && wd[2]) match_n = 0;
    if (hit) match_n = 1;
    if (w) begin
      if (a < 32'h400) begin
        m_ram[a[9:2]] = wd;
        m_known[a[9:2]] = 1;
      end
      case (wa)
        32'h1000: m_gpio = wd[15:0];
        32'h1008: tc_n = wd;
        32'h100C: m_tcmp = wd;
        32'h1010: begin m_en = wd[0]; m_ar = wd[1]; m_ie = wd[3]; end
        default: ;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = gin;
    m_tc = tc_n;
    m_match = match_n;
  endtask

  // One bus cycle: drive, take the edge, settle #1, advance the model.
  task automatic step(input logic [31:0] a, input logic w, input logic [31:0] wd);
    addr_i = a; we_i = w; wdata_i = wd;
    exp_rd = m_read(a, exp_known);
    @(posedge clk);
    if (rst) m_reset();
    else m_edge(a, w, wd, gpio_in);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_gpio;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'h0};
    tbl[1]  = '{32'h0000_0013, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0};
    tbl[2]  = '{32'h0000_0010, 1'b1, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, 16'h0};
    tbl[3]  = '{32'h0000_0010, 1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111, 16'h0};
    tbl[4]  = '{32'h0000_0011, 1'b0, 32'h0,         1'b1, 32'h2222_2222, 16'h0};
    tbl[5]  = '{32'h0000_1000, 1'b1, 32'hFFFF_A5A5, 1'b1, 32'h0,         16'hA5A5};
    tbl[6]  = '{32'h0000_1002, 1'b0, 32'h0,         1'b1, 32'h0000_A5A5, 16'hA5A5};
    tbl[7]  = '{32'h0000_1004, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,         16'hA5A5};
    tbl[8]  = '{32'h0000_1004, 1'b0, 32'h0,         1'b1, 32'h0,         16'hA5A5};
    tbl[9]  = '{32'h0000_2000, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0,         16'hA5A5};
    tbl[10] = '{32'h0000_2000, 1'b0, 32'h0,         1'b1, 32'h0,         16'hA5A5};
    tbl[11] = '{32'h0000_100C, 1'b1, 32'h0000_0007, 1'b1, 32'h0,         16'hA5A5};
    tbl[12] = '{32'h0000_100C, 1'b0, 32'h0,         1'b1, 32'h0000_0007, 16'hA5A5};
    tbl[13] = '{32'h0000_1010, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0,         16'hA5A5};
    tbl[14] = '{32'h0000_1010, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 16'hA5A5};
    tbl[15] = '{32'h0000_1008, 1'b1, 32'h1234_5678, 1'b1, 32'h0,         16'hA5A5};
    tbl[16] = '{32'h0000_1008, 1'b0, 32'h0,         1'b1, 32'h1234_5678, 16'hA5A5};
    tbl[17] = '{32'h0000_0000, 1'b1, 32'h0BAD_C0DE, 1'b0, 32'h0,         16'hA5A5};
    tbl[18] = '{32'h0000_0400, 1'b1, 32'h5555_5555, 1'b1, 32'h0,         16'hA5A5};
    tbl[19] = '{32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h0BAD_C0DE, 16'hA5A5};
    tbl[20] = '{32'h0000_03FC, 1'b1, 32'h7777_0001, 1'b0, 32'h0,         16'hA5A5};
    tbl[21] = '{32'h0000_03FF, 1'b0, 32'h0,         1'b1, 32'h7777_0001, 16'hA5A5};

    for (int i = 0; i < 256; i++) m_known[i] = 0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_gpio", {16'h0, gpio_out}, 32'h0);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].addr, tbl[i].we, tbl[i].wdata);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata_o, tbl[i].exp_rd);
      chk($sformatf("vec%0d_gpio", i), {16'h0, gpio_out}, {16'h0, tbl[i].exp_gpio});
      chk($sformatf("vec%0d_irq", i), {31'h0, irq_o}, 32'h0);
    end

    // GPIO_IN synchroniser: visible on the third read edge after the change
    gpio_in = 16'h3C3C;
    step(32'h1004, 0, 0); chk("sync_e1", rdata_o, 32'h0);
    step(32'h1004, 0, 0); chk("sync_e2", rdata_o, 32'h0);
    step(32'h1004, 0, 0); chk("sync_e3", rdata_o, 32'h0000_3C3C);

    // Timer with autoreload: TCMP=5, count 0..5 then 0
    step(32'h1010, 1, 32'h0);
    step(32'h100C, 1, 32'd5);
    step(32'h1008, 1, 32'd0);
    step(32'h1010, 1, 32'hB);
    for (int k = 0; k < 7; k++) begin
      step(32'h1008, 0, 0);
      chk($sformatf("tmr_count%0d", k), rdata_o, (k == 6) ? 32'd0 : 32'(k));
      if (k == 4) chk("tmr_irq_before", {31'h0, irq_o}, 32'h0);
      if (k >= 5) chk($sformatf("tmr_irq%0d", k), {31'h0, irq_o}, 32'h1);
    end
    step(32'h1010, 1, 32'hF);
    chk("tmr_ctrl_prewrite", rdata_o, 32'hF);
    chk("tmr_w1c_irq", {31'h0, irq_o}, 32'h0);
    step(32'h1010, 0, 0);
    chk("tmr_ctrl_cleared", rdata_o, 32'hB);

    // New match on the same edge as W1C: match wins
    step(32'h1010, 1, 32'h4);
    step(32'h100C, 1, 32'd3);
    step(32'h1008, 1, 32'd0);
    step(32'h1010, 1, 32'h9);
    for (int k = 0; k < 3; k++) begin
      step(32'h1008, 0, 0);
      chk($sformatf("pri_count%0d", k), rdata_o, 32'(k));
    end
    step(32'h1010, 1, 32'hD);
    chk("pri_irq_kept", {31'h0, irq_o}, 32'h1);
    step(32'h1010, 0, 0);
    chk("pri_ctrl", rdata_o, 32'hD);
    step(32'h1010, 1, 32'hD);
    chk("pri_w1c_irq", {31'h0, irq_o}, 32'h0);

    // TCOUNT store beats increment; wrap at 0xFFFF_FFFF
    step(32'h1008, 1, 32'h100);
    step(32'h1008, 0, 0); chk("tc_write_pri", rdata_o, 32'h100);
    step(32'h1008, 0, 0); chk("tc_after_write", rdata_o, 32'h101);
    step(32'h1008, 1, 32'hFFFF_FFFF);
    step(32'h1008, 0, 0); chk("tc_max", rdata_o, 32'hFFFF_FFFF);
    step(32'h1008, 0, 0); chk("tc_wrap", rdata_o, 32'h0);

    // Asynchronous reset while TCOUNT=3, EN=1
    step(32'h1010, 1, 32'h0);
    step(32'h100C, 1, 32'd2);
    step(32'h1008, 1, 32'd0);
    step(32'h1010, 1, 32'h9);
    repeat (3) step(32'h1000, 0, 0);
    chk("prerst_irq", {31'h0, irq_o}, 32'h1);
    chk("prerst_rdata", rdata_o, 32'h0000_A5A5);
    #3 rst = 1'b1;
    m_reset();
    #1;
    chk("rst_async_gpio", {16'h0, gpio_out}, 32'h0);
    chk("rst_async_rdata", rdata_o, 32'h0);
    chk("rst_async_irq", {31'h0, irq_o}, 32'h0);
    step(32'h1000, 1, 32'h1234);
    chk("rst_we_ignored", {16'h0, gpio_out}, 32'h0);
    rst = 1'b0;
    step(32'h1008, 0, 0); chk("postrst_tcount", rdata_o, 32'h0);
    step(32'h1010, 0, 0); chk("postrst_tctrl", rdata_o, 32'h0);
    step(32'h100C, 0, 0); chk("postrst_tcmp", rdata_o, 32'h0);
    step(32'h2000, 0, 0); chk("postrst_unmapped", rdata_o, 32'h0);

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, wd;
      logic w;
      int unsigned r;
      r = $urandom_range(0, 9);
      w = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      case (r)
        0, 1, 2: a = {22'h0, 4'($urandom_range(0, 15)), 4'h0} | 32'($urandom_range(0, 15));
        3:       a = 32'h3F0 | 32'($urandom_range(0, 15));
        4:       a = 32'h1000;
        5:       a = 32'h1004;
        6: begin a = 32'h1008; wd = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12)); end
        7: begin a = 32'h100C; wd = 32'($urandom_range(0, 12)); end
        8:       a = 32'h1010;
        default: begin
          case ($urandom_range(0, 3))
            0: a = 32'h400;
            1: a = 32'h1014;
            2: a = 32'h2000;
            default: a = 32'hFFFF_FFFC;
          endcase
        end
      endcase
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) gpio_in = 16'($urandom);
      step(a, w, wd);
      if (exp_known) chk($sformatf("rnd%0d_rdata", n), rdata_o, exp_rd);
      chk($sformatf("rnd%0d_gpio", n), {16'h0, gpio_out}, {16'h0, m_gpio});
      chk($sformatf("rnd%0d_irq", n), {31'h0, irq_o}, {31'h0, m_match & m_ie});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
